// File: rtl/brazo_pkg.sv
// Shared types and constants for the pose teach-and-replay path.
// Holds the sequencer state encoding and the memory depth helper.
package brazo_pkg;

   typedef enum logic [2:0] {
      REC,
      PLAY_EMPTY,
      PLAY_READ,
      PLAY_LOAD,
      PLAY_DWELL
   } state_t;

   localparam int DEFAULT_DATA_WIDTH = 8;

   function automatic int pose_depth(input int depth_log2);
      return 1 << depth_log2;
   endfunction

endpackage

// File: rtl/pose_ram.sv
// Simple dual-port pose store: one synchronous write port and one registered read port.
// Deliberately reset-free so it maps onto block RAM or LUTRAM.
module pose_ram
   import brazo_pkg::*;
#(
   parameter int WIDTH  = 3 * DEFAULT_DATA_WIDTH,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int DEPTH = pose_depth(ADDR_W);

   logic [WIDTH-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
      rdata <= mem_reg[raddr];
   end

endmodule

// File: rtl/pose_sequencer.sv
// Teach-and-replay stage: passes live poses through while recording, then loops
// the stored poses with a fixed dwell per pose.
module pose_sequencer
   import brazo_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int DEPTH_LOG2   = 3,
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_play,
   input  logic                  rec_strobe,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] in_x,
   input  logic [DATA_WIDTH-1:0] in_y,
   input  logic [DATA_WIDTH-1:0] in_z,
   output logic [DATA_WIDTH-1:0] out_x,
   output logic [DATA_WIDTH-1:0] out_y,
   output logic [DATA_WIDTH-1:0] out_z,
   output logic                  out_valid,
   output logic [DEPTH_LOG2:0]   count,
   output logic [DEPTH_LOG2-1:0] index,
   output logic                  full,
   output logic                  overflow
);

   localparam int POSE_W  = 3 * DATA_WIDTH;
   localparam int DEPTH   = pose_depth(DEPTH_LOG2);
   localparam int DWELL_W = $clog2(DWELL_CYCLES);
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
   // The READ and LOAD cycles plus the transition cycle make up the rest of the dwell.
   localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL_CYCLES - 3);

   state_t                state_reg,     state_next;
   logic [DEPTH_LOG2:0]   count_reg,     count_next;
   logic [DEPTH_LOG2-1:0] index_reg,     index_next;
   logic [DWELL_W-1:0]    dwell_reg,     dwell_next;
   logic [POSE_W-1:0]     out_pose_reg,  out_pose_next;
   logic                  out_valid_reg, out_valid_next;
   logic                  overflow_reg,  overflow_next;
   logic                  strobe_prev_reg;
   logic                  clear_prev_reg;

   logic                  strobe_rise;
   logic                  clear_rise;
   logic                  ram_we;
   logic [POSE_W-1:0]     live_pose;
   logic [POSE_W-1:0]     ram_rdata;
   logic [DATA_WIDTH-1:0] out_axis [3];

   assign live_pose   = {in_x, in_y, in_z};
   assign strobe_rise = rec_strobe & ~strobe_prev_reg;
   assign clear_rise  = clear & ~clear_prev_reg;
   assign full        = (count_reg == DEPTH_CNT);

   pose_ram #(
      .WIDTH  (POSE_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_pose_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (count_reg[DEPTH_LOG2-1:0]),
      .wdata (live_pose),
      .raddr (index_reg),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= REC;
         count_reg       <= '0;
         index_reg       <= '0;
         dwell_reg       <= '0;
         out_pose_reg    <= '0;
         out_valid_reg   <= 1'b0;
         overflow_reg    <= 1'b0;
         strobe_prev_reg <= 1'b1;
         clear_prev_reg  <= 1'b1;
      end else begin
         state_reg       <= state_next;
         count_reg       <= count_next;
         index_reg       <= index_next;
         dwell_reg       <= dwell_next;
         out_pose_reg    <= out_pose_next;
         out_valid_reg   <= out_valid_next;
         overflow_reg    <= overflow_next;
         strobe_prev_reg <= rec_strobe;
         clear_prev_reg  <= clear;
      end
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      index_next     = index_reg;
      dwell_next     = dwell_reg;
      out_pose_next  = out_pose_reg;
      out_valid_next = out_valid_reg;
      overflow_next  = 1'b0;
      ram_we         = 1'b0;

      if (state_reg == REC) begin
         out_pose_next  = live_pose;
         out_valid_next = 1'b1;
         index_next     = '0;
         dwell_next     = '0;
         if (clear_rise) begin
            count_next = '0;
         end else if (strobe_rise) begin
            if (full) begin
               overflow_next = 1'b1;
            end else begin
               ram_we     = rst;
               count_next = count_reg + 1'b1;
            end
         end
         // Decide on the post-update count so a same-cycle clear never replays an empty list.
         if (mode_play) begin
            if (count_next != '0) begin
               state_next = PLAY_READ;
            end else begin
               state_next     = PLAY_EMPTY;
               out_valid_next = 1'b0;
            end
         end
      end else if (!mode_play) begin
         state_next = REC;
         index_next = '0;
         dwell_next = '0;
      end else begin
         case (state_reg)
            PLAY_EMPTY: begin
               out_valid_next = 1'b0;
            end
            PLAY_READ: begin
               state_next = PLAY_LOAD;
            end
            PLAY_LOAD: begin
               out_pose_next  = ram_rdata;
               out_valid_next = 1'b1;
               dwell_next     = '0;
               state_next     = PLAY_DWELL;
            end
            PLAY_DWELL: begin
               if (dwell_reg == DWELL_LAST) begin
                  dwell_next = '0;
                  state_next = PLAY_READ;
                  if ({1'b0, index_reg} == count_reg - 1'b1) begin
                     index_next = '0;
                  end else begin
                     index_next = index_reg + 1'b1;
                  end
               end else begin
                  dwell_next = dwell_reg + 1'b1;
               end
            end
            default: begin
               state_next = REC;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      assign out_axis[gi] = out_pose_reg[(2 - gi) * DATA_WIDTH +: DATA_WIDTH];
   end

   assign out_x     = out_axis[0];
   assign out_y     = out_axis[1];
   assign out_z     = out_axis[2];
   assign out_valid = out_valid_reg;
   assign count     = count_reg;
   assign index     = index_reg;
   assign overflow  = overflow_reg;

endmodule
